ibuf4_deb: RTL and testbench

Four-channel input conditioner: the receive-side counterpart of the four-bit pad output buffer. Each external pin enters through a vendor IBUF primitive and a two-flop synchronizer, then passes through a per-channel debounce counter. The block presents a clean debounced level plus single-cycle rise and fall pulses to the core logic. It sits directly behind the top-level input ports, one instance per 4-pin group.

---
 rtl/ibuf4_deb_pkg.sv | 17 +
 rtl/ibuf4_deb_if.sv | 22 ++
 rtl/ibuf_deb1.sv | 69 ++++++
 rtl/ibuf4_deb.sv | 57 +++++
 tb/tb_ibuf4_deb.sv | 123 ++++++++++++
 5 files changed

// File: rtl/ibuf4_deb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ibuf4_deb_pkg
// Purpose  : Shared constants for the four-channel input conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package ibuf4_deb_pkg;

  // Number of pins handled by one conditioner instance
  localparam int NCH = 4;

  // Default debounce length (cycles) and the counter width that holds it
  localparam int DEF_DEB_CYCLES = 16;
  localparam int DEF_CNT_W      = 5;

endpackage : ibuf4_deb_pkg
`default_nettype wire

// File: rtl/ibuf4_deb_if.sv
`default_nettype none
// ============================================================================
// Module   : ibuf4_deb_if
// Purpose  : Pad-side inputs and conditioned outputs of one 4-pin group.
//            slave  = the conditioner (reads pads, drives level/pulses)
//            master = the core side (drives pads in a bench, reads results)
// Revision : 1.0 - initial release
// ============================================================================
interface ibuf4_deb_if;
  import ibuf4_deb_pkg::*;

  logic [NCH-1:0] I;     // raw pad inputs
  logic [NCH-1:0] O;     // debounced level
  logic [NCH-1:0] RISE;  // one-cycle 0->1 pulse per bit
  logic [NCH-1:0] FALL;  // one-cycle 1->0 pulse per bit
  logic           CHG;   // one-cycle pulse when any bit changed

  modport slave  (input I, output O, output RISE, output FALL, output CHG);
  modport master (output I, input O, input RISE, input FALL, input CHG);

endinterface : ibuf4_deb_if
`default_nettype wire

// File: rtl/ibuf_deb1.sv
`default_nettype none
// ============================================================================
// Module   : ibuf_deb1
// Purpose  : One input channel: pad buffer, two-flop synchronizer, debounce
//            counter, registered level and rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module ibuf_deb1 #(
  parameter int   DEB_CYCLES = 16,
  parameter int   CNT_W      = 5,
  parameter logic INIT       = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic pad,
  output logic      level,
  output logic      rise,
  output logic      fall,
  output logic      upd     // level updates on the coming edge
);

  // Terminal count: the edge on which cnt equals this commits the new level
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  // Behavioural stand-in for the vendor IBUF the tools place on the pad
  logic pad_buf;
  assign pad_buf = pad;

  (* ASYNC_REG = "TRUE" *) logic s1;
  (* ASYNC_REG = "TRUE" *) logic s2;
  logic [CNT_W-1:0] cnt;

  assign upd = (s2 != level) && (cnt == LAST);

  // Two-flop synchronizer bringing the asynchronous pad into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= INIT;
      s2 <= INIT;
    end else begin
      s1 <= pad_buf;
      s2 <= s1;
    end
  end

  // Debounce: count consecutive mismatches, commit on the terminal count,
  // and drop all progress the moment the synchronized input agrees again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= upd & s2;
      fall <= upd & ~s2;
      if (upd) begin
        level <= s2;
      end
      if ((s2 == level) || upd) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : ibuf_deb1
`default_nettype wire

// File: rtl/ibuf4_deb.sv
`default_nettype none
// ============================================================================
// Module   : ibuf4_deb
// Purpose  : Four-channel input conditioner; four independent debounced
//            channels plus a combined change pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ibuf4_deb
  import ibuf4_deb_pkg::*;
#(
  parameter int             DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int             CNT_W      = DEF_CNT_W,
  parameter logic [NCH-1:0] INIT       = '0
) (
  input wire logic   clk,
  input wire logic   rst,
  ibuf4_deb_if.slave bus
);

  logic [NCH-1:0] level_v;
  logic [NCH-1:0] rise_v;
  logic [NCH-1:0] fall_v;
  logic [NCH-1:0] upd_v;
  logic           chg_q;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    ibuf_deb1 #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W),
      .INIT       (INIT[n])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .pad   (bus.I[n]),
      .level (level_v[n]),
      .rise  (rise_v[n]),
      .fall  (fall_v[n]),
      .upd   (upd_v[n])
    );
  end

  // Combined change pulse, registered on the same edge as RISE/FALL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= |upd_v;
    end
  end

  assign bus.O    = level_v;
  assign bus.RISE = rise_v;
  assign bus.FALL = fall_v;
  assign bus.CHG  = chg_q;

endmodule : ibuf4_deb
`default_nettype wire

// File: tb/tb_ibuf4_deb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibuf4_deb
// Purpose  : Directed self-checking bench; one DEB_CYCLES=4 instance and one
//            DEB_CYCLES=1 instance sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibuf4_deb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  ibuf4_deb_if bus4 ();
  ibuf4_deb_if bus1 ();

  ibuf4_deb #(.DEB_CYCLES(4), .CNT_W(5), .INIT(4'b0000)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  ibuf4_deb #(.DEB_CYCLES(1), .CNT_W(5), .INIT(4'b0000)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {O,RISE,FALL,CHG} after each of n edges, given the level before
  // and after a change that commits on edge upd (upd=0: no change at all)
  task automatic watch(input string tag, input bit sel, input int n, input int upd,
                       input logic [3:0] o_old, input logic [3:0] o_new);
    logic [12:0] exp;
    logic [12:0] obs;
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      if (upd != 0 && e == upd)
        exp = {o_new, o_new & ~o_old, o_old & ~o_new, (o_new != o_old)};
      else if (upd != 0 && e > upd)
        exp = {o_new, 4'h0, 4'h0, 1'b0};
      else
        exp = {o_old, 4'h0, 4'h0, 1'b0};
      obs = sel ? {bus1.O, bus1.RISE, bus1.FALL, bus1.CHG}
                : {bus4.O, bus4.RISE, bus4.FALL, bus4.CHG};
      chk($sformatf("%s_e%0d", tag, e), 32'(obs), 32'(exp));
    end
  endtask

  // Assert reset between edges and verify outputs clear before any edge
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_async"}, 32'({bus4.O, bus4.RISE, bus4.FALL, bus4.CHG}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus4.I = 4'h0;
    bus1.I = 4'h0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    watch("idle", 1'b0, 20, 0, 4'h0, 4'h0);

    // Single rising pin, then back low
    bus4.I = 4'h1;
    watch("rise0", 1'b0, 9, 6, 4'h0, 4'h1);
    bus4.I = 4'h0;
    watch("fall0", 1'b0, 9, 6, 4'h1, 4'h0);

    // Three-cycle glitch must be filtered
    bus4.I = 4'h4;
    repeat (3) @(negedge clk);
    bus4.I = 4'h0;
    watch("glitch", 1'b0, 10, 0, 4'h0, 4'h0);

    // All pins together
    bus4.I = 4'hF;
    watch("allrise", 1'b0, 8, 6, 4'h0, 4'hF);

    // Reset while the level is high; pins stay high so they re-qualify
    @(posedge clk);
    async_reset("rst_hi");
    watch("rerise", 1'b0, 8, 6, 4'h0, 4'hF);
    bus4.I = 4'h0;
    watch("allfall", 1'b0, 8, 6, 4'hF, 4'h0);

    // Reset in the middle of a count on pin 1
    bus4.I = 4'h2;
    repeat (4) @(negedge clk);
    async_reset("rst_mid");
    watch("post_rst", 1'b0, 8, 6, 4'h0, 4'h2);
    bus4.I = 4'h0;
    watch("post_fall", 1'b0, 8, 6, 4'h2, 4'h0);

    // DEB_CYCLES=1 instance: pin 3 toggled every 5 cycles
    for (int t = 0; t < 4; t++) begin
      logic [3:0] prev;
      prev = bus1.I;
      bus1.I = {~bus1.I[3], 3'b000};
      watch($sformatf("d1_t%0d", t), 1'b1, 5, 3, prev, bus1.I);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ibuf4_deb
`default_nettype wire
